// File: rtl/transport_send_sched.sv
`default_nettype none
// ============================================================================
// Module   : transport_send_sched
// Purpose  : Round-robin arbiter that shares one transportSend packetizer
//            among NUM_REQ requesters. It latches the winner's cmd/data,
//            pulses sendData, tracks the busy window and aborts through a
//            watchdog if the packetizer never acknowledges.
// Revision : 1.0  initial release
// ============================================================================
module transport_send_sched #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [2*NUM_REQ-1:0]    req_cmd,
    input  logic [16*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      grant,
    output logic [1:0]              tx_cmd,
    output logic [15:0]             tx_data,
    output logic                    tx_send,
    input  logic                    tx_busy,
    output logic [2:0]              owner,
    output logic                    active,
    output logic                    done,
    output logic                    timeout_err
);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_issue     = 2'd1;
    localparam logic [1:0] c_st_wait_busy = 2'd2;
    localparam logic [1:0] c_st_wait_done = 2'd3;

    localparam logic [3:0] c_num_req = 4'(NUM_REQ);
    localparam logic [2:0] c_last    = 3'(NUM_REQ - 1);
    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    logic [1:0]         r_state;
    logic [2:0]         r_rr;
    logic [7:0]         r_wd_cnt;

    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    logic [3:0]         w_sum;
    logic [2:0]         w_sel;
    logic [NUM_REQ-1:0] w_grant;
    logic [2:0]         w_rr_next;

    // Rotate requests so bit 0 is the rr position, then take the first set bit
    // and map it back to an absolute requester index.
    always_comb begin
        w_rot   = NUM_REQ'({req, req} >> r_rr);
        w_found = 1'b0;
        w_sum   = 4'd0;
        w_sel   = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr} + 4'(k);
                w_sel   = (w_sum >= c_num_req) ? 3'(w_sum - c_num_req) : w_sum[2:0];
            end
        end
        w_grant   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
        w_rr_next = (owner == c_last) ? 3'd0 : owner + 3'd1;
    end

    // Scheduler FSM; every output is registered and pulses default low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_rr        <= 3'd0;
            r_wd_cnt    <= 8'd0;
            grant       <= '0;
            tx_cmd      <= 2'd0;
            tx_data     <= 16'd0;
            tx_send     <= 1'b0;
            owner       <= 3'd0;
            active      <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            grant       <= '0;
            tx_send     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // An externally held packetizer blocks new grants.
                    if (w_found && !tx_busy) begin
                        grant   <= w_grant;
                        owner   <= w_sel;
                        active  <= 1'b1;
                        tx_cmd  <= 2'(req_cmd >> {w_sel, 1'b0});
                        tx_data <= 16'(req_data >> {w_sel, 4'b0000});
                        r_state <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    tx_send  <= 1'b1;
                    r_wd_cnt <= 8'd0;
                    r_state  <= c_st_wait_busy;
                end
                c_st_wait_busy: begin
                    if (tx_busy) begin
                        r_state <= c_st_wait_done;
                    end else if (r_wd_cnt == c_timeout) begin
                        timeout_err <= 1'b1;
                        active      <= 1'b0;
                        r_rr        <= w_rr_next;
                        r_state     <= c_st_idle;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 8'd1;
                    end
                end
                c_st_wait_done: begin
                    if (!tx_busy) begin
                        done    <= 1'b1;
                        active  <= 1'b0;
                        r_rr    <= w_rr_next;
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_transport_send_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_transport_send_sched
// Purpose  : Self-checking bench for transport_send_sched. A transaction-level
//            reference model tracks the round-robin pointer and predicts the
//            winner, operand capture, pulse timing and watchdog expiry.
// Revision : 1.0  initial release
// ============================================================================
module tb_transport_send_sched;

    localparam int N = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [2*N-1:0]   req_cmd;
    logic [16*N-1:0]  req_data;
    logic [N-1:0]     grant;
    logic [1:0]       tx_cmd;
    logic [15:0]      tx_data;
    logic             tx_send;
    logic             tx_busy;
    logic [2:0]       owner;
    logic             active;
    logic             done;
    logic             timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int model_rr = 0;
    logic [1:0]  cmd_m  [N];
    logic [15:0] data_m [N];

    transport_send_sched #(.NUM_REQ(N), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .req(req), .req_cmd(req_cmd),
        .req_data(req_data), .grant(grant), .tx_cmd(tx_cmd),
        .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .owner(owner), .active(active), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it when observed differs from expected.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Winner: first requesting index at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int rr);
        for (int k = 0; k < N; k++)
            if (r[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_cmd[2*i +: 2]   = cmd_m[i];
            req_data[16*i +: 16] = data_m[i];
        end
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            cmd_m[i]  = 2'($urandom);
            data_m[i] = 16'($urandom);
        end
        drive_ops();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_txcmd"}, 32'(tx_cmd), 0);
        check({tag, "_txdata"}, 32'(tx_data), 0);
        check({tag, "_flags"}, {27'd0, tx_send, active, done, timeout_err, 1'b0}, 0);
        check({tag, "_owner"}, 32'(owner), 0);
    endtask

    // One transfer. Entered at a negedge with the DUT idle and req nonzero.
    // Packetizer raises busy d cycles after tx_send and holds it len cycles.
    task automatic xfer(input int d, input int len, input bit wd, input bit rst_mid, input bit scr);
        int sel;
        int seen;
        bit got_done;
        logic [1:0]  ecmd;
        logic [15:0] edata;
        sel = pick(req, model_rr);
        if (sel < 0) sel = 0;
        ecmd  = cmd_m[sel];
        edata = data_m[sel];
        @(negedge clk);
        check("grant", 32'(grant), 32'(1 << sel));
        check("owner", 32'(owner), 32'(sel));
        check("active_grant", 32'(active), 1);
        check("tx_cmd_grant", 32'(tx_cmd), 32'(ecmd));
        check("tx_data_grant", 32'(tx_data), 32'(edata));
        check("send_early", 32'(tx_send), 0);
        // Requests and operands outside IDLE must not disturb the transfer.
        req = N'($urandom);
        if (scr) randomize_ops();
        @(negedge clk);
        check("tx_send", 32'(tx_send), 1);
        check("grant_pulse", 32'(grant), 0);
        if (wd) begin
            seen = -1;
            got_done = 1'b0;
            for (int t = 1; t <= 300; t++) begin
                @(negedge clk);
                if (t == 1) check("send_pulse", 32'(tx_send), 0);
                if (done) got_done = 1'b1;
                if (timeout_err) begin
                    seen = t;
                    break;
                end
            end
            check("wd_cycles", 32'(seen), 256);
            check("wd_no_done", 32'(got_done), 0);
            check("wd_active", 32'(active), 0);
            model_rr = (sel + 1) % N;
        end else begin
            for (int t = 0; t < d; t++) begin
                @(negedge clk);
                check("pre_busy_active", 32'(active), 1);
                check("pre_busy_done", 32'(done), 0);
            end
            tx_busy = 1'b1;
            for (int t = 0; t < len; t++) begin
                @(negedge clk);
                check("busy_active", 32'(active), 1);
                check("busy_flags", {30'd0, done, timeout_err}, 0);
            end
            if (rst_mid) begin
                reset   = 1'b1;
                tx_busy = 1'b0;
                @(negedge clk);
                check_all_zero("rst_mid");
                reset    = 1'b0;
                model_rr = 0;
            end else begin
                tx_busy = 1'b0;
                @(negedge clk);
                check("done", 32'(done), 1);
                check("active_end", 32'(active), 0);
                check("timeout_end", 32'(timeout_err), 0);
                check("tx_cmd_hold", 32'(tx_cmd), 32'(ecmd));
                check("tx_data_hold", 32'(tx_data), 32'(edata));
                model_rr = (sel + 1) % N;
            end
        end
    endtask

    task automatic ext_busy(input int k);
        tx_busy = 1'b1;
        for (int t = 0; t < k; t++) begin
            @(negedge clk);
            check("ext_busy_grant", 32'(grant), 0);
            check("ext_busy_active", 32'(active), 0);
        end
        tx_busy = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        tx_busy = 1'b0;
        randomize_ops();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Single request with fixed operands.
        cmd_m[0] = 2'b01; data_m[0] = 16'h0044; drive_ops();
        req = 3'b001;
        xfer(2, 10, 1'b0, 1'b0, 1'b0);

        // All three requesting: strict rotation with distinct data.
        cmd_m[0] = 2'd1; data_m[0] = 16'h1111;
        cmd_m[1] = 2'd2; data_m[1] = 16'h2222;
        cmd_m[2] = 2'd3; data_m[2] = 16'h3333;
        drive_ops();
        for (int i = 0; i < 4; i++) begin
            req = 3'b111;
            xfer(0, 5, 1'b0, 1'b0, 1'b0);
        end

        // Requesters 0 and 2 alternate, then requester 1 joins.
        for (int i = 0; i < 4; i++) begin
            req = 3'b101;
            xfer(1, 3, 1'b0, 1'b0, 1'b0);
        end
        req = 3'b111;
        xfer(0, 2, 1'b0, 1'b0, 1'b0);

        // Watchdog expiry, then rotation continues past the aborted owner.
        req = 3'b001;
        xfer(0, 0, 1'b1, 1'b0, 1'b0);
        req = 3'b111;
        xfer(0, 1, 1'b0, 1'b0, 1'b0);

        // Resource held externally while idle.
        req = 3'b010;
        ext_busy(4);
        xfer(3, 2, 1'b0, 1'b0, 1'b0);

        // Reset during the busy window, then the pending request again.
        req = 3'b001;
        xfer(1, 3, 1'b0, 1'b1, 1'b0);
        req = 3'b001;
        xfer(0, 2, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            randomize_ops();
            req = N'($urandom_range(1, (1 << N) - 1));
            if ($urandom_range(0, 4) == 0) ext_busy($urandom_range(1, 4));
            xfer($urandom_range(0, 5), $urandom_range(1, 6), 1'b0,
                 (it % 10) == 9, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
